// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the hazard unit and its scoreboard.
package hazard_pkg;

    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_MAX_INFLIGHT = 4;
    localparam int DEF_CNT_W        = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits and in-flight count for long-latency ops that
// retire out of order through W. The op issuing in E this cycle is already
// reported busy by the hit lookups.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_longIssue,
    input  logic [ADDR_W-1:0]   i_rdE,
    input  logic                i_longDone,
    input  logic [ADDR_W-1:0]   i_rdW,
    input  logic [ADDR_W-1:0]   i_addrA,
    input  logic [ADDR_W-1:0]   i_addrB,
    input  logic [ADDR_W-1:0]   i_addrC,
    output logic                o_hitA,
    output logic                o_hitB,
    output logic                o_hitC,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [CNT_W-1:0]    o_inflight
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CNT_W-1:0]    r_inflight;

    function automatic logic sb_hit(input logic [ADDR_W-1:0] a);
        return (a != '0) && (r_busy[a] || (i_longIssue && (i_rdE == a)));
    endfunction

    // Next busy vector: completion clears, issue sets; set applied last so it wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (i_longDone && (i_rdW == ADDR_W'(i))) w_busy_nxt[i] = 1'b0;
            if (i_longIssue && (i_rdE == ADDR_W'(i))) w_busy_nxt[i] = 1'b1;
        end
    end

    // Busy vector and in-flight counter; a done with nothing outstanding is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_inflight <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (i_longIssue && !i_longDone) begin
                r_inflight <= r_inflight + ONE;
            end else if (!i_longIssue && i_longDone && (r_inflight != '0)) begin
                r_inflight <= r_inflight - ONE;
            end
        end
    end

    assign o_hitA     = sb_hit(i_addrA);
    assign o_hitB     = sb_hit(i_addrB);
    assign o_hitC     = sb_hit(i_addrC);
    assign o_busy     = r_busy;
    assign o_inflight = r_inflight;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: M/W forwarding selects, load-use,
// scoreboard RAW/WAW and long-unit capacity stalls, and branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   r1AddrD,
    input  logic [ADDR_W-1:0]   r2AddrD,
    input  logic [ADDR_W-1:0]   rdD,
    input  logic                regWriteD,
    input  logic                longOpD,
    input  logic [ADDR_W-1:0]   r1AddrE,
    input  logic [ADDR_W-1:0]   r2AddrE,
    input  logic [ADDR_W-1:0]   rdE,
    input  logic                regSrcE0,
    input  logic                longIssueE,
    input  logic                pcSelE,
    input  logic [ADDR_W-1:0]   rdM,
    input  logic                regWriteM,
    input  logic [ADDR_W-1:0]   rdW,
    input  logic                regWriteW,
    input  logic                longDoneW,
    output logic [1:0]          fwdAE,
    output logic [1:0]          fwdBE,
    output logic                stallF,
    output logic                stallD,
    output logic                flushD,
    output logic                flushE,
    output logic [NUM_REGS-1:0] sbBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         perfStall,
    output logic [31:0]         perfFlush,
    output logic [31:0]         perfCap
`endif
);

    logic             w_hit_r1;
    logic             w_hit_r2;
    logic             w_hit_rd;
    logic [CNT_W-1:0] w_inflight;
    logic [CNT_W:0]   w_cap_lhs;
    logic [CNT_W:0]   w_cap_rhs;
    logic             w_lw_stall;
    logic             w_raw_stall;
    logic             w_waw_stall;
    logic             w_cap_stall;
    logic             w_stall;

    // M has priority over W; both ignore writes to x0.
    function automatic fwd_sel_t fwd_sel(input logic [ADDR_W-1:0] a);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (regWriteM && (rdM != '0) && (a == rdM)) begin
            sel = FWD_M;
        end else if (regWriteW && (rdW != '0) && (a == rdW)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_longIssue (longIssueE),
        .i_rdE       (rdE),
        .i_longDone  (longDoneW),
        .i_rdW       (rdW),
        .i_addrA     (r1AddrD),
        .i_addrB     (r2AddrD),
        .i_addrC     (rdD),
        .o_hitA      (w_hit_r1),
        .o_hitB      (w_hit_r2),
        .o_hitC      (w_hit_rd),
        .o_busy      (sbBusy),
        .o_inflight  (w_inflight)
    );

    assign fwdAE = fwd_sel(r1AddrE);
    assign fwdBE = fwd_sel(r2AddrE);

    assign w_lw_stall  = regSrcE0 && (rdE != '0) && ((r1AddrD == rdE) || (r2AddrD == rdE));
    assign w_raw_stall = w_hit_r1 || w_hit_r2;
    assign w_waw_stall = regWriteD && w_hit_rd;

    // inflight + issue - done >= MAX, rearranged so nothing underflows.
    assign w_cap_lhs   = {1'b0, w_inflight} + {{CNT_W{1'b0}}, longIssueE};
    assign w_cap_rhs   = (CNT_W+1)'(MAX_INFLIGHT) + {{CNT_W{1'b0}}, longDoneW};
    assign w_cap_stall = longOpD && (w_cap_lhs >= w_cap_rhs);

    assign w_stall = w_lw_stall || w_raw_stall || w_waw_stall || w_cap_stall;

    assign stallF = w_stall;
    assign stallD = w_stall;
    assign flushD = pcSelE;
    assign flushE = w_stall || pcSelE;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_cap;

    // Free-running wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_cap   <= '0;
        end else begin
            if (w_stall)     r_perf_stall <= r_perf_stall + 32'd1;
            if (pcSelE)      r_perf_flush <= r_perf_flush + 32'd1;
            if (w_cap_stall) r_perf_cap   <= r_perf_cap + 32'd1;
        end
    end

    assign perfStall = r_perf_stall;
    assign perfFlush = r_perf_flush;
    assign perfCap   = r_perf_cap;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard. The driver applies one vector
// per cycle and queues its hand-computed expectation; a monitor on the
// falling edge pops and compares.
module tb_hazard_scoreboard;

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  r1D, r2D, rdD;
        logic        wD, lopD;
        logic [4:0]  r1E, r2E, rdE;
        logic        ldE, issE, pcS;
        logic [4:0]  rdM;
        logic        wM;
        logic [4:0]  rdW;
        logic        wW, doneW;
        logic [1:0]  eA, eB;
        logic        eStall, eFlD;
        logic [31:0] eBusy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [4:0]  r1AddrD, r2AddrD, rdD;
    logic        regWriteD, longOpD;
    logic [4:0]  r1AddrE, r2AddrE, rdE;
    logic        regSrcE0, longIssueE, pcSelE;
    logic [4:0]  rdM;
    logic        regWriteM;
    logic [4:0]  rdW;
    logic        regWriteW, longDoneW;
    logic [1:0]  fwdAE, fwdBE;
    logic        stallF, stallD, flushD, flushE;
    logic [31:0] sbBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perfStall, perfFlush, perfCap;
`endif

    vec_t q[$];
    vec_t e;
    vec_t v;
    int   checks = 0;
    int   errors = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .r1AddrD    (r1AddrD),
        .r2AddrD    (r2AddrD),
        .rdD        (rdD),
        .regWriteD  (regWriteD),
        .longOpD    (longOpD),
        .r1AddrE    (r1AddrE),
        .r2AddrE    (r2AddrE),
        .rdE        (rdE),
        .regSrcE0   (regSrcE0),
        .longIssueE (longIssueE),
        .pcSelE     (pcSelE),
        .rdM        (rdM),
        .regWriteM  (regWriteM),
        .rdW        (rdW),
        .regWriteW  (regWriteW),
        .longDoneW  (longDoneW),
        .fwdAE      (fwdAE),
        .fwdBE      (fwdBE),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .flushE     (flushE),
        .sbBusy     (sbBusy)
`ifdef HAZARD_PERF_EN
        ,
        .perfStall  (perfStall),
        .perfFlush  (perfFlush),
        .perfCap    (perfCap)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t idle(input string n);
        vec_t t;
        t.name = n;   t.rst = 1'b0;
        t.r1D = '0;   t.r2D = '0;   t.rdD = '0;  t.wD = 1'b0; t.lopD = 1'b0;
        t.r1E = '0;   t.r2E = '0;   t.rdE = '0;
        t.ldE = 1'b0; t.issE = 1'b0; t.pcS = 1'b0;
        t.rdM = '0;   t.wM = 1'b0;  t.rdW = '0;  t.wW = 1'b0; t.doneW = 1'b0;
        t.eA = 2'b00; t.eB = 2'b00; t.eStall = 1'b0; t.eFlD = 1'b0; t.eBusy = '0;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        @(posedge clk);
        #1;
        rst = t.rst;
        r1AddrD = t.r1D; r2AddrD = t.r2D; rdD = t.rdD;
        regWriteD = t.wD; longOpD = t.lopD;
        r1AddrE = t.r1E; r2AddrE = t.r2E; rdE = t.rdE;
        regSrcE0 = t.ldE; longIssueE = t.issE; pcSelE = t.pcS;
        rdM = t.rdM; regWriteM = t.wM;
        rdW = t.rdW; regWriteW = t.wW; longDoneW = t.doneW;
        q.push_back(t);
    endtask

    task automatic check(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", n, f, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, "fwdAE",  32'(fwdAE),  32'(e.eA));
            check(e.name, "fwdBE",  32'(fwdBE),  32'(e.eB));
            check(e.name, "stallF", 32'(stallF), 32'(e.eStall));
            check(e.name, "stallD", 32'(stallD), 32'(e.eStall));
            check(e.name, "flushD", 32'(flushD), 32'(e.eFlD));
            check(e.name, "flushE", 32'(flushE), 32'(e.eStall | e.eFlD));
            check(e.name, "sbBusy", sbBusy,      e.eBusy);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        v = idle("init");
        v.rst = 1'b1;
        rst = 1'b1;
        r1AddrD = '0; r2AddrD = '0; rdD = '0; regWriteD = 1'b0; longOpD = 1'b0;
        r1AddrE = '0; r2AddrE = '0; rdE = '0; regSrcE0 = 1'b0; longIssueE = 1'b0;
        pcSelE = 1'b0; rdM = '0; regWriteM = 1'b0; rdW = '0; regWriteW = 1'b0;
        longDoneW = 1'b0;
        repeat (2) @(posedge clk);

        v = idle("rst_quiet"); v.rst = 1'b1; drive(v);
        v = idle("idle"); drive(v);

        // forwarding
        v = idle("fwd_m_prio"); v.rdM = 5; v.wM = 1; v.rdW = 5; v.wW = 1;
        v.r1E = 5; v.r2E = 5; v.eA = 2'b10; v.eB = 2'b10; drive(v);
        v = idle("fwd_w_only"); v.rdM = 5; v.wM = 0; v.rdW = 5; v.wW = 1;
        v.r1E = 5; v.r2E = 5; v.eA = 2'b01; v.eB = 2'b01; drive(v);
        v = idle("fwd_none"); v.rdM = 6; v.wM = 1; v.rdW = 5; v.wW = 0;
        v.r1E = 5; v.r2E = 5; drive(v);
        v = idle("fwd_mixed"); v.rdM = 6; v.wM = 1; v.rdW = 7; v.wW = 1;
        v.r1E = 6; v.r2E = 7; v.eA = 2'b10; v.eB = 2'b01; drive(v);
        v = idle("fwd_x0"); v.rdM = 0; v.wM = 1; v.rdW = 0; v.wW = 1; drive(v);

        // load-use
        v = idle("lw_stall"); v.ldE = 1; v.rdE = 7; v.r2D = 7; v.eStall = 1; drive(v);
        v = idle("lw_after"); drive(v);
        v = idle("lw_rd0"); v.ldE = 1; v.rdE = 0; drive(v);

        // branch flush
        v = idle("branch"); v.pcS = 1; v.eFlD = 1; drive(v);

        // scoreboard RAW
        v = idle("raw_issue"); v.issE = 1; v.rdE = 9; v.r1D = 9; v.eStall = 1; drive(v);
        v = idle("raw_busy"); v.r1D = 9; v.eStall = 1; v.eBusy = 32'h200; drive(v);
        v = idle("raw_done"); v.r2D = 9; v.doneW = 1; v.rdW = 9; v.wW = 1;
        v.eStall = 1; v.eBusy = 32'h200; drive(v);
        v = idle("raw_release"); v.r1D = 9; drive(v);

        // scoreboard WAW
        v = idle("waw_issue"); v.issE = 1; v.rdE = 10; v.wD = 1; v.rdD = 10; v.eStall = 1; drive(v);
        v = idle("waw_nowrite"); v.rdD = 10; v.eBusy = 32'h400; drive(v);
        v = idle("waw_done"); v.doneW = 1; v.rdW = 10; v.eBusy = 32'h400; drive(v);

        // same-cycle set and clear
        v = idle("sc_issue"); v.issE = 1; v.rdE = 3; drive(v);
        v = idle("sc_both"); v.issE = 1; v.rdE = 3; v.doneW = 1; v.rdW = 3; v.eBusy = 32'h8; drive(v);
        v = idle("sc_kept"); v.doneW = 1; v.rdW = 3; v.eBusy = 32'h8; drive(v);
        v = idle("sc_clear"); drive(v);

        // capacity
        v = idle("cap_i1"); v.issE = 1; v.rdE = 1; v.lopD = 1; drive(v);
        v = idle("cap_i2"); v.issE = 1; v.rdE = 2; v.lopD = 1; v.eBusy = 32'h2; drive(v);
        v = idle("cap_i3"); v.issE = 1; v.rdE = 3; v.lopD = 1; v.eBusy = 32'h6; drive(v);
        v = idle("cap_i4"); v.issE = 1; v.rdE = 4; v.lopD = 1; v.eBusy = 32'hE; v.eStall = 1; drive(v);
        v = idle("cap_full"); v.lopD = 1; v.eBusy = 32'h1E; v.eStall = 1; drive(v);
        v = idle("cap_done"); v.lopD = 1; v.doneW = 1; v.rdW = 1; v.eBusy = 32'h1E; drive(v);
        v = idle("cap_three"); v.lopD = 1; v.eBusy = 32'h1C; drive(v);
        v = idle("drain2"); v.doneW = 1; v.rdW = 2; v.eBusy = 32'h1C; drive(v);
        v = idle("drain3"); v.doneW = 1; v.rdW = 3; v.eBusy = 32'h18; drive(v);
        v = idle("drain4"); v.doneW = 1; v.rdW = 4; v.eBusy = 32'h10; drive(v);
        v = idle("drained"); drive(v);

        // reset mid-flight
        v = idle("mf_i2"); v.issE = 1; v.rdE = 2; drive(v);
        v = idle("mf_i4"); v.issE = 1; v.rdE = 4; v.eBusy = 32'h4; drive(v);
        v = idle("mf_rst"); v.rst = 1; v.eBusy = 32'h14; drive(v);
        v = idle("mf_spurious"); v.doneW = 1; v.rdW = 2; drive(v);
        v = idle("post_i5"); v.issE = 1; v.rdE = 5; v.lopD = 1; drive(v);
        v = idle("post_i6"); v.issE = 1; v.rdE = 6; v.lopD = 1; v.eBusy = 32'h20; drive(v);
        v = idle("post_i7"); v.issE = 1; v.rdE = 7; v.lopD = 1; v.eBusy = 32'h60; drive(v);
        v = idle("post_three"); v.lopD = 1; v.eBusy = 32'hE0; drive(v);
        v = idle("post_i8"); v.issE = 1; v.rdE = 8; v.lopD = 1; v.eBusy = 32'hE0; v.eStall = 1; drive(v);
        v = idle("final_rst"); v.rst = 1; v.eBusy = 32'h1E0; drive(v);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
